// File: rtl/cache_pkg.sv
// Shared types and sizing for the cache miss-fill controller.
package cache_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    localparam int unsigned BLOCK_WORDS = 8;
    localparam int unsigned WORD_OFF_W  = 3;
    localparam int unsigned BLOCK_OFF_W = 4;
    localparam int unsigned CNT_W       = 4;

endpackage

// File: rtl/fill_counter.sv
// Saturating up-counter with synchronous clear; done flags the terminal count.
module fill_counter
    import cache_pkg::*;
#(
    parameter int unsigned LIMIT = BLOCK_WORDS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    assign done = (count == CNT_W'(LIMIT));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !done) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss handler: stalls the pipeline, streams one block from memory in
// word order, writes the data array per returned word and the tag on the last.
module cache_fill_fsm
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned BLOCK_WORDS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  miss_detected,
    input  logic [ADDR_W-1:0]     miss_address,
    output logic                  fsm_busy,
    output logic                  memory_read,
    output logic [ADDR_W-1:0]     memory_address,
    input  logic                  memory_data_valid,
    input  logic [DATA_W-1:0]     memory_data,
    output logic                  write_data_array,
    output logic [WORD_OFF_W-1:0] cache_word_off,
    output logic [DATA_W-1:0]     cache_write_data,
    output logic                  write_tag_array
);

    localparam int unsigned TAG_W = ADDR_W - BLOCK_OFF_W;

    state_t           state;
    logic [TAG_W-1:0] base_tag;
    logic [CNT_W-1:0] issue_cnt;
    logic [CNT_W-1:0] recv_cnt;
    logic             issue_done;
    logic             recv_done;
    logic             in_fill;
    logic             word_accept;
    logic             last_word;
    logic             unused_bits;

    assign in_fill     = (state == FILL);
    assign word_accept = in_fill && memory_data_valid;
    assign last_word   = word_accept && (recv_cnt == CNT_W'(BLOCK_WORDS - 1));

    // Counters sit at zero while idle so every fill starts at word 0.
    fill_counter #(.LIMIT(BLOCK_WORDS)) u_issue_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!in_fill),
        .inc   (memory_read),
        .count (issue_cnt),
        .done  (issue_done)
    );

    fill_counter #(.LIMIT(BLOCK_WORDS)) u_recv_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!in_fill),
        .inc   (word_accept),
        .count (recv_cnt),
        .done  (recv_done)
    );

    // Block base is latched at the miss so later address changes cannot leak in.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            base_tag <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss_detected) begin
                        base_tag <= miss_address[ADDR_W-1:BLOCK_OFF_W];
                        state    <= FILL;
                    end
                end
                FILL: begin
                    if (last_word) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign fsm_busy         = in_fill || miss_detected;
    assign memory_read      = in_fill && !issue_done;
    assign memory_address   = memory_read
                              ? {base_tag, issue_cnt[WORD_OFF_W-1:0], 1'b0}
                              : '0;
    assign write_data_array = word_accept;
    assign cache_word_off   = recv_cnt[WORD_OFF_W-1:0];
    assign cache_write_data = memory_data;
    assign write_tag_array  = last_word;

    assign unused_bits = ^{miss_address[BLOCK_OFF_W-1:0], issue_cnt[CNT_W-1], recv_done};

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Scoreboard bench for cache_fill_fsm with a latency/gap memory model.
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        miss_detected = 1'b0;
    logic [15:0] miss_address = 16'h0;
    logic        fsm_busy;
    logic        memory_read;
    logic [15:0] memory_address;
    logic        memory_data_valid = 1'b0;
    logic [15:0] memory_data = 16'h1357;
    logic        write_data_array;
    logic [2:0]  cache_word_off;
    logic [15:0] cache_write_data;
    logic        write_tag_array;

    always #5 clk = ~clk;

    cache_fill_fsm #(.ADDR_W(16), .DATA_W(16), .BLOCK_WORDS(8)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .fsm_busy          (fsm_busy),
        .memory_read       (memory_read),
        .memory_address    (memory_address),
        .memory_data_valid (memory_data_valid),
        .memory_data       (memory_data),
        .write_data_array  (write_data_array),
        .cache_word_off    (cache_word_off),
        .cache_write_data  (cache_write_data),
        .write_tag_array   (write_tag_array)
    );

    typedef struct {
        int          due;
        logic [15:0] data;
    } mem_t;

    typedef struct {
        logic [2:0]  off;
        logic [15:0] data;
    } wr_t;

    localparam logic [15:0] DMASK = 16'h5A5A;

    mem_t        mem_q[$];
    logic [15:0] exp_addr_q[$];
    wr_t         exp_wr_q[$];
    int          exp_tag = 0;

    int cyc = 0;
    int lat = 4;
    int gap_left = 0;
    bit rnd_gap = 1'b0;
    int n_checks = 0;
    int n_pass = 0;
    int wr_count = 0;
    int tag_count = 0;
    int last_wr_cyc = 0;
    int idle_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: each request returns (address ^ DMASK) after lat cycles, in order.
    always @(negedge clk) begin
        if (rst_n && memory_read) begin
            mem_t m;
            m.due  = cyc + lat;
            m.data = memory_address ^ DMASK;
            mem_q.push_back(m);
        end
    end

    always @(posedge clk) begin
        #1;
        memory_data_valid = 1'b0;
        if (gap_left > 0) begin
            gap_left--;
        end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            memory_data_valid = 1'b1;
            memory_data       = mem_q[0].data;
            void'(mem_q.pop_front());
            gap_left = rnd_gap ? int'($urandom_range(3, 0)) : 0;
        end
    end

    // Monitor: pops scoreboard entries whenever the DUT issues a read or write.
    always @(negedge clk) begin
        if (rst_n) begin
            if (memory_read) begin
                if (exp_addr_q.size() == 0) chk("rd_unexpected", 32'(memory_address), 32'hFFFF_FFFF);
                else chk("rd_addr", 32'(memory_address), 32'(exp_addr_q.pop_front()));
            end
            if (write_data_array) begin
                wr_count++;
                if (cache_word_off == 3'd7) last_wr_cyc = cyc;
                if (exp_wr_q.size() == 0) begin
                    chk("wr_unexpected", 32'(cache_word_off), 32'hFFFF_FFFF);
                end else begin
                    wr_t w;
                    w = exp_wr_q.pop_front();
                    chk("wr_off", 32'(cache_word_off), 32'(w.off));
                    chk("wr_data", 32'(cache_write_data), 32'(w.data));
                end
            end
            if (write_tag_array) begin
                tag_count++;
                if (exp_tag == 0) begin
                    chk("tag_unexpected", 32'(write_tag_array), 32'h0);
                end else begin
                    exp_tag--;
                    chk("tag_with_last_word", 32'(write_data_array && cache_word_off == 3'd7), 32'h1);
                end
            end
        end
    end

    task automatic expect_fill(input logic [15:0] base);
        for (int k = 0; k < 8; k++) begin
            wr_t w;
            exp_addr_q.push_back(base + 16'(2 * k));
            w.off  = 3'(k);
            w.data = (base + 16'(2 * k)) ^ DMASK;
            exp_wr_q.push_back(w);
        end
        exp_tag++;
    endtask

    // Called at posedge+1; returns at posedge+1 of the first fill cycle.
    task automatic start_fill(input logic [15:0] addr);
        expect_fill(addr & 16'hFFF0);
        miss_detected = 1'b1;
        miss_address  = addr;
        @(negedge clk);
        chk("miss_cycle_busy", 32'(fsm_busy), 32'h1);
        @(posedge clk); #1;
        miss_detected = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (fsm_busy && n < 200);
        idle_cyc = cyc;
        chk({name, "_idle"}, 32'(fsm_busy), 32'h0);
        chk({name, "_addr_left"}, 32'(exp_addr_q.size()), 32'h0);
        chk({name, "_wr_left"}, 32'(exp_wr_q.size()), 32'h0);
        chk({name, "_tag_left"}, 32'(exp_tag), 32'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        int n, w0, t0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        chk("rst_busy", 32'(fsm_busy), 32'h0);
        chk("rst_read", 32'(memory_read), 32'h0);
        chk("rst_addr", 32'(memory_address), 32'h0);
        chk("rst_wda", 32'(write_data_array), 32'h0);
        chk("rst_wta", 32'(write_tag_array), 32'h0);
        chk("rst_off", 32'(cache_word_off), 32'h0);
        chk("rst_passthru", 32'(cache_write_data), 32'h1357);
        @(posedge clk); #1;

        // Fixed 4-cycle memory: cycle-exact timing of the whole fill.
        lat = 4;
        start_fill(16'h1236);
        for (int i = 1; i < 14; i++) begin
            @(negedge clk);
            chk($sformatf("t1_busy_c%0d", i), 32'(fsm_busy), 32'(i <= 12));
            chk($sformatf("t1_read_c%0d", i), 32'(memory_read), 32'(i <= 8));
            chk($sformatf("t1_wda_c%0d", i), 32'(write_data_array), 32'(i >= 5 && i <= 12));
            chk($sformatf("t1_tag_c%0d", i), 32'(write_tag_array), 32'(i == 12));
            @(posedge clk); #1;
        end
        chk("t1_addr_left", 32'(exp_addr_q.size()), 32'h0);
        chk("t1_wr_left", 32'(exp_wr_q.size()), 32'h0);
        chk("t1_tag_left", 32'(exp_tag), 32'h0);

        // Randomly gapped valids.
        lat = 1;
        rnd_gap = 1'b1;
        w0 = wr_count;
        t0 = tag_count;
        start_fill(16'h4A18);
        wait_idle("t2");
        chk("t2_release", 32'(idle_cyc), 32'(last_wr_cyc + 1));
        chk("t2_writes", 32'(wr_count - w0), 32'd8);
        chk("t2_tags", 32'(tag_count - t0), 32'd1);
        rnd_gap = 1'b0;
        repeat (4) begin @(posedge clk); #1; end

        // Miss held high with a changing address, then back-to-back fill.
        lat = 4;
        expect_fill(16'h1230);
        expect_fill(16'hFFF0);
        miss_detected = 1'b1;
        miss_address  = 16'h1236;
        repeat (4) begin @(posedge clk); #1; end
        miss_address = 16'hFFF0;
        t0 = tag_count;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (tag_count == t0 && n < 50);
        chk("t3_first_tag", 32'(tag_count), 32'(t0 + 1));
        @(negedge clk);
        chk("t3_busy_reaccept", 32'(fsm_busy), 32'h1);
        @(posedge clk); #1;
        miss_detected = 1'b0;
        @(negedge clk);
        chk("t3_second_read", 32'(memory_read), 32'h1);
        chk("t3_second_addr", 32'(memory_address), 32'hFFF0);
        @(posedge clk); #1;
        wait_idle("t3");

        // Reset in the middle of a fill.
        lat = 4;
        w0 = wr_count;
        t0 = tag_count;
        start_fill(16'h3344);
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (wr_count - w0 < 3 && n < 50);
        chk("t4_three_writes", 32'(wr_count - w0), 32'd3);
        rst_n = 1'b0;
        mem_q.delete();
        exp_addr_q.delete();
        exp_wr_q.delete();
        exp_tag = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("t4_busy", 32'(fsm_busy), 32'h0);
        chk("t4_read", 32'(memory_read), 32'h0);
        chk("t4_addr", 32'(memory_address), 32'h0);
        chk("t4_wda", 32'(write_data_array), 32'h0);
        chk("t4_wta", 32'(write_tag_array), 32'h0);
        chk("t4_off", 32'(cache_word_off), 32'h0);
        chk("t4_no_tag", 32'(tag_count - t0), 32'h0);
        @(posedge clk); #1;
        start_fill(16'h2002);
        wait_idle("t4b");

        // Spurious valid while idle.
        @(negedge clk); #1;
        begin
            mem_t m;
            m.due  = cyc;
            m.data = 16'hBEEF;
            mem_q.push_back(m);
        end
        @(negedge clk);
        chk("t5_passthru", 32'(cache_write_data), 32'hBEEF);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("t5_busy_%0d", i), 32'(fsm_busy), 32'h0);
            chk($sformatf("t5_wda_%0d", i), 32'(write_data_array), 32'h0);
            chk($sformatf("t5_wta_%0d", i), 32'(write_tag_array), 32'h0);
        end
        @(posedge clk); #1;

        // Top-of-memory block: no wrap past 0xFFFE.
        lat = 2;
        start_fill(16'hFFFE);
        wait_idle("t6");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
